// File: rtl/uart_fmt_sender.sv
// Renders one signed matrix element plus format flags into an ASCII byte string
// and streams it to the UART transmitter over a registered valid/ready handshake.
module uart_fmt_sender #(
  parameter int ELEM_W    = 8,
  parameter int BUF_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ELEM_W-1:0] data,
  input  logic              last_col,
  input  logic              newline,
  input  logic              id,
  input  logic              sum_head,
  input  logic              sum_elem,
  output logic              ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              done,
  output logic              drop
);

  localparam int LEN_W = $clog2(BUF_DEPTH + 1);
  localparam int STR_W = 8 * BUF_DEPTH;

  typedef enum logic [2:0] {M_NL, M_ID, M_HEAD, M_ELEM, M_PLAIN} mode_e;
  typedef enum logic {S_IDLE, S_SEND} state_e;

  state_e             r_state;
  logic [STR_W-1:0]   r_buf;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_idx;
  logic [7:0]         r_tx_data;
  logic               r_tx_valid;
  logic               r_ready;
  logic               r_done;
  logic               r_drop;

  logic               w_neg;
  logic [ELEM_W:0]    w_ext;
  logic [ELEM_W:0]    w_mag;
  logic [7:0]         w_dig_h;
  logic [7:0]         w_dig_t;
  logic [7:0]         w_dig_o;
  mode_e              w_mode;
  logic [STR_W-1:0]   w_str;
  logic [LEN_W-1:0]   w_len;
  logic [LEN_W-1:0]   w_nxt_idx;
  logic               w_accept;

  // Magnitude is one bit wider than the element so the most negative value negates cleanly.
  assign w_neg   = data[ELEM_W-1];
  assign w_ext   = {data[ELEM_W-1], data};
  assign w_mag   = w_neg ? -w_ext : w_ext;
  assign w_dig_h = 8'h30 + 8'(w_mag / 100);
  assign w_dig_t = 8'h30 + 8'((w_mag / 10) % 10);
  assign w_dig_o = 8'h30 + 8'(w_mag % 10);

  always_comb begin
    if (newline)       w_mode = M_NL;
    else if (id)       w_mode = M_ID;
    else if (sum_head) w_mode = M_HEAD;
    else if (sum_elem) w_mode = M_ELEM;
    else               w_mode = M_PLAIN;
  end

  function automatic logic [STR_W-1:0] put(input logic [STR_W-1:0] s, input int pos,
                                           input logic [7:0] b);
    logic [STR_W-1:0] r;
    r = s;
    r[pos*8 +: 8] = b;
    return r;
  endfunction

  // Byte 0 of the string sits in the least significant byte; n tracks the write position.
  // NOTE: every output of this block gets a default first so no latch can be inferred.
  always_comb begin
    int n;
    w_str = '0;
    n     = 0;
    if (w_mode == M_NL) begin
      w_str = put(w_str, n, 8'h0D); n = n + 1;
      w_str = put(w_str, n, 8'h0A); n = n + 1;
    end else begin
      if (w_mode == M_ELEM) begin w_str = put(w_str, n, 8'h5B); n = n + 1; end
      if (w_neg)            begin w_str = put(w_str, n, 8'h2D); n = n + 1; end
      if (w_mag >= 100)     begin w_str = put(w_str, n, w_dig_h); n = n + 1; end
      if (w_mag >= 10)      begin w_str = put(w_str, n, w_dig_t); n = n + 1; end
      w_str = put(w_str, n, w_dig_o); n = n + 1;
      if (w_mode == M_ID) begin
        w_str = put(w_str, n, 8'h3A); n = n + 1;
        w_str = put(w_str, n, 8'h0D); n = n + 1;
        w_str = put(w_str, n, 8'h0A); n = n + 1;
      end else if (w_mode == M_HEAD) begin
        w_str = put(w_str, n, 8'h20); n = n + 1;
      end else begin
        if (w_mode == M_ELEM) begin w_str = put(w_str, n, 8'h5D); n = n + 1; end
        if (last_col) begin
          w_str = put(w_str, n, 8'h0D); n = n + 1;
          w_str = put(w_str, n, 8'h0A); n = n + 1;
        end else begin
          w_str = put(w_str, n, 8'h20); n = n + 1;
        end
      end
    end
    w_len = LEN_W'(n);
  end

  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_nxt_idx = r_idx + LEN_W'(1);

  // NOTE: the byte buffer holds only data qualified by r_len/r_idx, so it carries no reset.
  always_ff @(posedge clk) begin
    if (!rst && w_accept) r_buf <= w_str;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_idx      <= '0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_drop <= start && !r_ready;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len      <= w_len;
            r_idx      <= '0;
            r_tx_data  <= w_str[7:0];
            r_tx_valid <= 1'b1;
            r_ready    <= 1'b0;
            r_state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            if (r_idx == r_len - LEN_W'(1)) begin
              r_done     <= 1'b1;
              r_tx_valid <= 1'b0;
              r_ready    <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_idx     <= w_nxt_idx;
              r_tx_data <= r_buf[w_nxt_idx*8 +: 8];
            end
          end
        end
      endcase
    end
  end

  assign ready    = r_ready;
  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign done     = r_done;
  assign drop     = r_drop;

endmodule

// File: tb/tb_uart_fmt_sender.sv
// Scoreboard bench for uart_fmt_sender: stimulus pushes hand-computed bytes,
// a negedge monitor pops and compares every handshaken byte and the done pulse.
module tb_uart_fmt_sender;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data;
  logic       last_col, newline, id, sum_head, sum_elem;
  logic       ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       done;
  logic       drop;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] b;
    logic       last;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [7:0]  d;
    logic        lc, nl, idf, sh, se;
    logic [63:0] s;
    int          n;
  } vec_t;
  vec_t vecs[7];

  uart_fmt_sender #(.ELEM_W(8), .BUF_DEPTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data     (data),
    .last_col (last_col),
    .newline  (newline),
    .id       (id),
    .sum_head (sum_head),
    .sum_elem (sum_elem),
    .ready    (ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .done     (done),
    .drop     (drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected string is right-aligned: s = 64'h3520 with n=2 means 0x35 then 0x20.
  task automatic push_exp(input logic [63:0] s, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.b    = s[8*(n-1-i) +: 8];
      e.last = (i == n - 1);
      q.push_back(e);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic issue(input vec_t v);
    check("ready_before_start", ready, 1'b1);
    push_exp(v.s, v.n);
    data = v.d; last_col = v.lc; newline = v.nl; id = v.idf; sum_head = v.sh; sum_elem = v.se;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    newline = 1'b0; id = 1'b0; sum_head = 1'b0; sum_elem = 1'b0; last_col = 1'b0;
    check("ready_after_accept", ready, 1'b0);
    check("valid_after_accept", tx_valid, 1'b1);
  endtask

  // Counts cycles from the accept edge until done; optional 1,0,0 tx_ready pattern.
  task automatic wait_done(input int exp_cycles, input logic stall_pat);
    int cyc = 0;
    while (cyc < 100) begin
      tx_ready = stall_pat ? ((cyc % 3) == 0) : 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (done) break;
    end
    tx_ready = 1'b1;
    check("done_cycle", cyc, exp_cycles);
    check("ready_after_done", ready, 1'b1);
    check("valid_after_done", tx_valid, 1'b0);
  endtask

  // Monitor: compares each handshaken byte, the done pulse and stall stability.
  initial begin
    exp_t       e;
    logic       next_done = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] held = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        next_done  = 1'b0;
        prev_stall = 1'b0;
      end else begin
        check("done_pulse", done, next_done);
        if (prev_stall) begin
          check("stall_valid", tx_valid, 1'b1);
          check("stall_data", tx_data, held);
        end
        next_done = 1'b0;
        if (tx_valid && tx_ready) begin
          if (q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL tx_byte unexpected actual=%0h required=none at %0t", tx_data, $time);
          end else begin
            e = q.pop_front();
            check("tx_byte", tx_data, e.b);
            next_done = e.last;
          end
        end
        prev_stall = tx_valid && !tx_ready;
        held       = tx_data;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vecs[0] = '{8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h3132370D0A,       5}; // 127 plain, last_col
    vecs[1] = '{8'hF9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h2D3720,           3}; // -7 sum_head ignores last_col
    vecs[2] = '{8'h0A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h5B31305D20,       5}; // [10] space
    vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h303A0D0A,         4}; // id beats sum_elem
    vecs[4] = '{8'h64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h31303020,         4}; // 100, inner zeros kept
    vecs[5] = '{8'hF7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h2D3920,           3}; // sum_head beats sum_elem
    vecs[6] = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h2D31323820,       5}; // -128 plain

    rst = 1'b1; start = 1'b0; data = 8'h00; last_col = 1'b0; newline = 1'b0;
    id = 1'b0; sum_head = 1'b0; sum_elem = 1'b0; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready, 1'b1);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_done", done, 1'b0);
    check("rst_drop", drop, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 5 plain: first byte visible right after accept, ready back after two handshakes
    issue('{8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h3520, 2});
    check("first_byte", tx_data, 8'h35);
    wait_done(2, 1'b0);

    // -128 sum_elem last_col: 8 consecutive bytes
    issue('{8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h5B2D3132385D0D0A, 8});
    wait_done(8, 1'b0);

    // newline, id, sum_head together: newline wins
    issue('{8'h7F, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0D0A, 2});
    wait_done(2, 1'b0);

    // 3 id under a 1,0,0 tx_ready pattern: handshakes at cycles 1,4,7,10
    issue('{8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h333A0D0A, 4});
    wait_done(10, 1'b1);

    foreach (vecs[i]) begin
      v = vecs[i];
      issue(v);
      wait_done(v.n, 1'b0);
    end

    // start one cycle after an accept is dropped; stream in flight unchanged
    issue('{8'h2A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h343220, 3});
    data = 8'h63; id = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; id = 1'b0;
    check("drop_pulse", drop, 1'b1);
    @(posedge clk); #1;
    check("drop_single", drop, 1'b0);
    tx_ready = 1'b1;
    begin
      int cyc = 0;
      while (!done && cyc < 50) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("drop_stream_done", cyc, 1);
    end
    check("drop_ready_after", ready, 1'b1);

    // reset after the second byte of "-12 ": no done, remaining bytes discarded
    @(posedge clk); #1;
    issue('{8'hF4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h2D313220, 4});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_tx_valid", tx_valid, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_ready", ready, 1'b1);
    check("mid_rst_leftover", q.size(), 2);
    q.delete();
    @(posedge clk); #1;
    check("post_rst_done", done, 1'b0);
    issue('{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h3020, 2});
    wait_done(2, 1'b0);

    @(posedge clk); #1;
    check("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
